frame_sched: RTL and testbench
==============================

FRAME_SCHED -- requirements
Module: frame_sched

Interface
REQ-001 Parameter AW, 6, RAM word-address width.
REQ-002 Parameter LATCH_CYC, 2500, line-low latch interval in clk cycles (50 us at 50 MHz); legal range 1..65535.
REQ-003 Parameter TMO_CYC, 4095, word_done watchdog limit in clk cycles; legal range 1..65535.
REQ-004 clk  in  1  single system clock; all logic on rising edge.
REQ-005 Rst  in  1  reset, synchronous, active-high.
REQ-006 auto_en  in  1  1 = re-send current read bank continuously when no swap is pending.
REQ-007 wr_done  in  1  one-cycle pulse: writer finished filling wr_bank.
REQ-008 frame_len  in  AW  index of last word in frame (words sent = frame_len+1).
REQ-009 word_done  in  1  one-cycle pulse from serializer: current word fully sent.
REQ-010 word_req  out  1  one-cycle pulse: serializer fetches and sends word at {rd_bank, rd_addr}.
REQ-011 rd_addr  out  AW  word address within read bank.
REQ-012 rd_bank  out  1  bank being read by serializer.
REQ-013 wr_bank  out  1  bank owned by writer; always ~rd_bank.
REQ-014 line_low  out  1  1 during latch interval; downstream forces data line low.
REQ-015 busy  out  1  1 whenever state != IDLE.
REQ-016 frame_cnt  out  8  completed frames, wraps 255 -> 0.
REQ-017 err_ovr  out  1  sticky: wr_done received while a swap already pending.
REQ-018 err_tmo  out  1  sticky: watchdog expired in WAIT.

Function
REQ-019 States SHALL be IDLE, START, SEND, WAIT, LATCH; encoding free.
REQ-020 IDLE: if pending=1 -> toggle rd_bank/wr_bank, clear pending, go START; else if auto_en=1 -> go START; else stay.
REQ-021 START: rd_addr <= 0, latch frame_len into internal len register, go SEND (frame_len changes mid-frame SHALL have no effect).
REQ-022 SEND: word_req = 1 for exactly this one cycle, clear watchdog, go WAIT.
REQ-023 WAIT: on word_done, if rd_addr == len -> go LATCH, else rd_addr <= rd_addr+1 and go SEND.
REQ-024 WAIT: watchdog counts each cycle without word_done; on reaching TMO_CYC -> set err_tmo, go LATCH (frame abandoned).
REQ-025 LATCH: line_low = 1; load counter LATCH_CYC on entry, decrement per cycle; after exactly LATCH_CYC cycles in LATCH -> frame_cnt+1, go IDLE.
REQ-026 Minimum word-to-word spacing: word_done in cycle N -> next word_req in cycle N+1.
REQ-027 word_done outside WAIT SHALL be ignored.
REQ-028 wr_done with pending=0 -> pending <= 1 next cycle, in any state.
REQ-029 wr_done with pending=1 and not consumed same cycle -> err_ovr <= 1, pending stays 1, no extra swap.
REQ-030 wr_done in the same cycle IDLE consumes pending -> swap occurs, pending <= 1 (new frame), no error.
REQ-031 Swap SHALL only occur in IDLE; never mid-frame or mid-latch.
REQ-032 frame_len = 0 -> one word per frame; frame_len = 2^AW-1 -> rd_addr reaches all-ones without wrap.
REQ-033 Error flags cleared only by Rst.

Reset
REQ-034 Rst=1 at a rising edge SHALL, in any state, force next cycle: IDLE, rd_addr 0, word_req 0, line_low 0, busy 0, rd_bank 1, wr_bank 0, frame_cnt 0, pending 0, err_ovr 0, err_tmo 0, counters 0.
REQ-035 Rst mid-frame SHALL abort with no further word_req and no frame_cnt increment.

Verification
REQ-036 Rst, frame_len=2, wr_done pulse, word_done 3 cycles after each word_req -> rd_bank 0, word_req at rd_addr 0,1,2, line_low for LATCH_CYC cycles, frame_cnt=1, IDLE.
REQ-037 auto_en=1, no wr_done, frame_len=0 -> back-to-back frames on same bank, frame_cnt increments each frame, banks never toggle.
REQ-038 Two wr_done pulses during one frame -> err_ovr=1 after second, exactly one swap at next IDLE.
REQ-039 word_done withheld after word_req, TMO_CYC=16 -> err_tmo=1, LATCH entered 16 cycles after WAIT entry, frame_cnt increments after latch.
REQ-040 Rst asserted in WAIT at rd_addr=5 -> next cycle all outputs at reset values, no word_req until new START.
REQ-041 frame_len changed from 3 to 1 during SEND of word 0 -> 4 words sent; next frame sends 2.

Source files
------------

// File: rtl/frame_sched.sv
`default_nettype none
// ============================================================================
//  Module      : frame_sched
//  Description : Double-buffered frame scheduler. Hands a RAM bank to a word
//                serializer, requests one word at a time, guards each word
//                with a watchdog, and ends every frame with a line-low latch
//                interval. Bank swaps happen only between frames, in IDLE.
//
//  Ports
//    clk        in   system clock, rising edge
//    Rst        in   synchronous active-high reset
//    auto_en    in   re-send current read bank when no swap is pending
//    wr_done    in   pulse: writer finished filling wr_bank
//    frame_len  in   index of last word in frame (words = frame_len+1)
//    word_done  in   pulse: serializer finished the current word
//    word_req   out  pulse: fetch/send word at {rd_bank, rd_addr}
//    rd_addr    out  word address within the read bank
//    rd_bank    out  bank read by the serializer
//    wr_bank    out  bank owned by the writer (always ~rd_bank)
//    line_low   out  high during the latch interval
//    busy       out  high whenever not idle
//    frame_cnt  out  completed frames, wraps modulo 256
//    err_ovr    out  sticky: wr_done arrived while a swap was already pending
//    err_tmo    out  sticky: word_done watchdog expired
//
//  Revision    : 1.0  initial release
// ============================================================================
module frame_sched #(
   parameter int AW        = 6,
   parameter int LATCH_CYC = 2500,
   parameter int TMO_CYC   = 4095
) (
   input  logic          clk,
   input  logic          Rst,
   input  logic          auto_en,
   input  logic          wr_done,
   input  logic [AW-1:0] frame_len,
   input  logic          word_done,
   output logic          word_req,
   output logic [AW-1:0] rd_addr,
   output logic          rd_bank,
   output logic          wr_bank,
   output logic          line_low,
   output logic          busy,
   output logic [7:0]    frame_cnt,
   output logic          err_ovr,
   output logic          err_tmo
);

   localparam logic [2:0] c_st_idle  = 3'd0;
   localparam logic [2:0] c_st_start = 3'd1;
   localparam logic [2:0] c_st_send  = 3'd2;
   localparam logic [2:0] c_st_wait  = 3'd3;
   localparam logic [2:0] c_st_latch = 3'd4;

   localparam logic [15:0]   c_latch_load = 16'(LATCH_CYC);
   localparam logic [15:0]   c_tmo_last   = 16'(TMO_CYC - 1);
   localparam logic [AW-1:0] c_addr_one   = {{(AW-1){1'b0}}, 1'b1};

   logic [2:0]    r_state;
   logic [AW-1:0] r_rd_addr;
   logic [AW-1:0] r_len;
   logic          r_rd_bank;
   logic          r_pending;
   logic [15:0]   r_wdog;
   logic [15:0]   r_lcnt;
   logic [7:0]    r_frame_cnt;
   logic          r_err_ovr;
   logic          r_err_tmo;

   // The pending swap is taken in the same cycle IDLE looks at it; a wr_done
   // arriving in that cycle re-arms pending for the following frame.
   logic w_consume;
   assign w_consume = (r_state == c_st_idle) && r_pending;

   always_ff @(posedge clk) begin
      if (Rst) begin
         r_state     <= c_st_idle;
         r_rd_addr   <= '0;
         r_len       <= '0;
         r_rd_bank   <= 1'b1;
         r_pending   <= 1'b0;
         r_wdog      <= '0;
         r_lcnt      <= '0;
         r_frame_cnt <= '0;
         r_err_ovr   <= 1'b0;
         r_err_tmo   <= 1'b0;
      end else begin
         case (r_state)
            c_st_idle: begin
               if (r_pending) begin
                  r_rd_bank <= ~r_rd_bank;
                  r_state   <= c_st_start;
               end else if (auto_en) begin
                  r_state   <= c_st_start;
               end
            end
            c_st_start: begin
               // Length is frozen here so mid-frame edits only affect the
               // next frame.
               r_rd_addr <= '0;
               r_len     <= frame_len;
               r_state   <= c_st_send;
            end
            c_st_send: begin
               r_wdog  <= '0;
               r_state <= c_st_wait;
            end
            c_st_wait: begin
               if (word_done) begin
                  if (r_rd_addr == r_len) begin
                     r_lcnt  <= c_latch_load;
                     r_state <= c_st_latch;
                  end else begin
                     r_rd_addr <= r_rd_addr + c_addr_one;
                     r_state   <= c_st_send;
                  end
               end else if (r_wdog == c_tmo_last) begin
                  // TMO_CYC silent cycles in WAIT: give up on the frame.
                  r_err_tmo <= 1'b1;
                  r_lcnt    <= c_latch_load;
                  r_state   <= c_st_latch;
               end else begin
                  r_wdog <= r_wdog + 16'd1;
               end
            end
            c_st_latch: begin
               if (r_lcnt == 16'd1) begin
                  r_frame_cnt <= r_frame_cnt + 8'd1;
                  r_state     <= c_st_idle;
               end else begin
                  r_lcnt <= r_lcnt - 16'd1;
               end
            end
            default: r_state <= c_st_idle;
         endcase

         if (wr_done) begin
            if (!r_pending || w_consume) begin
               r_pending <= 1'b1;
            end else begin
               r_err_ovr <= 1'b1;
            end
         end else if (w_consume) begin
            r_pending <= 1'b0;
         end
      end
   end

   assign word_req  = (r_state == c_st_send);
   assign rd_addr   = r_rd_addr;
   assign rd_bank   = r_rd_bank;
   assign wr_bank   = ~r_rd_bank;
   assign line_low  = (r_state == c_st_latch);
   assign busy      = (r_state != c_st_idle);
   assign frame_cnt = r_frame_cnt;
   assign err_ovr   = r_err_ovr;
   assign err_tmo   = r_err_tmo;

endmodule
`default_nettype wire

// File: tb/tb_frame_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_frame_sched
//  Description : Self-checking bench for frame_sched (AW=4, LATCH_CYC=5,
//                TMO_CYC=16). Table of single-frame scenarios, hand-written
//                multi-cycle sequences, and a randomized run against a
//                timeline model of the frame schedule.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_frame_sched;

   localparam int AW  = 4;
   localparam int L   = 5;
   localparam int TMO = 16;
   localparam int RND_CYC = 12000;

   logic          clk = 1'b0;
   logic          Rst = 1'b1;
   logic          auto_en = 1'b0;
   logic          wr_done = 1'b0;
   logic [AW-1:0] frame_len = '0;
   logic          word_done = 1'b0;
   logic          word_req;
   logic [AW-1:0] rd_addr;
   logic          rd_bank;
   logic          wr_bank;
   logic          line_low;
   logic          busy;
   logic [7:0]    frame_cnt;
   logic          err_ovr;
   logic          err_tmo;

   frame_sched #(.AW(AW), .LATCH_CYC(L), .TMO_CYC(TMO)) dut (
      .clk(clk), .Rst(Rst), .auto_en(auto_en), .wr_done(wr_done),
      .frame_len(frame_len), .word_done(word_done), .word_req(word_req),
      .rd_addr(rd_addr), .rd_bank(rd_bank), .wr_bank(wr_bank),
      .line_low(line_low), .busy(busy), .frame_cnt(frame_cnt),
      .err_ovr(err_ovr), .err_tmo(err_tmo)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int cyc = 0;

   // serializer responder: word_done resp_dly cycles after each word_req
   bit resp_en = 1'b0;
   int resp_dly = 1;
   int resp_cnt = 0;

   // outputs sampled at the falling edge of the cycle just stepped
   bit s_req, s_bank, s_low, s_busy;
   int s_addr, s_cyc;

   typedef struct {
      int len; int dly; bit wr; bit exp_bank;
      int exp_words; int exp_low; int exp_busy; int exp_fcnt;
   } vec_t;
   vec_t tbl[5];

   task automatic chk(input string name, input int got, input int want);
      checks++;
      if (got != want) begin
         errors++;
         $display("FAIL %s: got %0d, want %0d", name, got, want);
      end
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, " word_req"},  int'(word_req), 0);
      chk({tag, " rd_addr"},   int'(rd_addr), 0);
      chk({tag, " rd_bank"},   int'(rd_bank), 1);
      chk({tag, " wr_bank"},   int'(wr_bank), 0);
      chk({tag, " line_low"},  int'(line_low), 0);
      chk({tag, " busy"},      int'(busy), 0);
      chk({tag, " frame_cnt"}, int'(frame_cnt), 0);
      chk({tag, " err_ovr"},   int'(err_ovr), 0);
      chk({tag, " err_tmo"},   int'(err_tmo), 0);
   endtask

   // Sample the current cycle, then advance to #1 after the next edge.
   task automatic step();
      @(negedge clk);
      s_req  = word_req;
      s_addr = int'(rd_addr);
      s_bank = rd_bank;
      s_low  = line_low;
      s_busy = busy;
      s_cyc  = cyc;
      if (resp_en && word_req) resp_cnt = resp_dly;
      @(posedge clk);
      #1;
      cyc++;
      word_done = 1'b0;
      if (resp_cnt > 0) begin
         resp_cnt--;
         if (resp_cnt == 0) word_done = 1'b1;
      end
   endtask

   // Step until a busy period has been seen and ended (one idle cycle sampled).
   task automatic run_frame(output int words, output int low, output int busy_n,
                            output int bank, output int maxaddr);
      bit seen = 1'b0;
      bit fin = 1'b0;
      words = 0; low = 0; busy_n = 0; bank = -1; maxaddr = -1;
      for (int n = 0; n < 400; n++) begin
         step();
         if (s_busy) begin seen = 1'b1; busy_n++; end
         if (s_low) low++;
         if (s_req) begin
            words++;
            bank = int'(s_bank);
            if (s_addr > maxaddr) maxaddr = s_addr;
         end
         if (seen && !s_busy) begin fin = 1'b1; break; end
      end
      chk("frame completes within bound", int'(fin), 1);
   endtask

   // timeline model state for the randomized run
   int  m_req[16];
   int  m_done[16];
   int  m_len, m_lat_s, m_idle;
   bit  m_valid, m_pend, m_bank, m_ovr;
   logic [7:0] m_fcnt;

   initial begin
      int w, lo, bu, bk, ma, t_req, t_low, n;
      bit e_req, e_low, e_busy, in_wait, wd_real, consume, ok;
      int e_addr;

      tbl[0] = '{2, 3, 1'b1, 1'b0,  3, L, 18, 1};
      tbl[1] = '{0, 1, 1'b0, 1'b0,  1, L,  8, 2};
      tbl[2] = '{15, 1, 1'b1, 1'b1, 16, L, 38, 3};
      tbl[3] = '{5, 2, 1'b1, 1'b0,  6, L, 24, 4};
      tbl[4] = '{1, 4, 1'b0, 1'b0,  2, L, 16, 5};

      // ---------------- reset state
      Rst = 1'b1;
      step(); step();
      Rst = 1'b0;
      chk_reset("reset");

      // ---------------- table of single frames
      resp_en = 1'b1;
      for (int i = 0; i < 5; i++) begin
         frame_len = AW'(tbl[i].len);
         resp_dly  = tbl[i].dly;
         if (tbl[i].wr) wr_done = 1'b1; else auto_en = 1'b1;
         step();
         wr_done = 1'b0;
         auto_en = 1'b0;
         run_frame(w, lo, bu, bk, ma);
         chk($sformatf("vec%0d words", i), w, tbl[i].exp_words);
         chk($sformatf("vec%0d last addr", i), ma, tbl[i].len);
         chk($sformatf("vec%0d bank", i), bk, int'(tbl[i].exp_bank));
         chk($sformatf("vec%0d latch cycles", i), lo, tbl[i].exp_low);
         chk($sformatf("vec%0d busy cycles", i), bu, tbl[i].exp_busy);
         chk($sformatf("vec%0d frame_cnt", i), int'(frame_cnt), tbl[i].exp_fcnt);
      end

      // ---------------- two wr_done pulses in one frame
      frame_len = 4'd3; resp_dly = 2;
      auto_en = 1'b1; step(); auto_en = 1'b0;
      step(); step();
      wr_done = 1'b1; step(); wr_done = 1'b0;
      chk("ovr after first wr_done", int'(err_ovr), 0);
      step(); step();
      wr_done = 1'b1; step(); wr_done = 1'b0;
      chk("ovr after second wr_done", int'(err_ovr), 1);
      run_frame(w, lo, bu, bk, ma);
      chk("ovr frame bank", bk, 0);
      run_frame(w, lo, bu, bk, ma);
      chk("ovr swapped frame bank", bk, 1);
      chk("ovr swapped frame words", w, 4);
      n = 0;
      for (int i = 0; i < 20; i++) begin step(); if (s_busy) n++; end
      chk("ovr single swap, no extra frame", n, 0);
      chk("ovr frame_cnt", int'(frame_cnt), 7);

      // ---------------- watchdog timeout
      resp_en = 1'b0; frame_len = 4'd0;
      auto_en = 1'b1; step(); auto_en = 1'b0;
      t_req = -1; t_low = -1;
      for (int i = 0; i < 50; i++) begin step(); if (s_req) begin t_req = s_cyc; break; end end
      for (int i = 0; i < 50; i++) begin step(); if (s_low) begin t_low = s_cyc; break; end end
      chk("tmo latch entry after word_req", t_low - t_req, TMO + 1);
      chk("tmo err_tmo", int'(err_tmo), 1);
      run_frame(w, lo, bu, bk, ma);
      chk("tmo frame_cnt", int'(frame_cnt), 8);

      // ---------------- reset in WAIT at rd_addr 5
      resp_en = 1'b1; resp_dly = 2; frame_len = 4'd8;
      auto_en = 1'b1; step(); auto_en = 1'b0;
      n = 0;
      for (int i = 0; i < 100; i++) begin step(); if (s_req && s_addr == 5) begin n = 1; break; end end
      chk("rst reached word 5", n, 1);
      Rst = 1'b1; step();
      chk_reset("rst_mid");
      Rst = 1'b0; resp_cnt = 0; word_done = 1'b0;
      n = 0;
      for (int i = 0; i < 30; i++) begin step(); if (s_req) n++; end
      chk("rst no word_req after", n, 0);
      chk("rst frame_cnt stays", int'(frame_cnt), 0);

      // ---------------- frame_len edit during SEND of word 0
      resp_dly = 1; frame_len = 4'd3; auto_en = 1'b1;
      for (int i = 0; i < 20; i++) begin step(); if (s_busy) break; end
      frame_len = 4'd1;
      run_frame(w, lo, bu, bk, ma);
      chk("len edit frame1 words", w, 4);
      run_frame(w, lo, bu, bk, ma);
      chk("len edit frame2 words", w, 2);
      auto_en = 1'b0;
      run_frame(w, lo, bu, bk, ma);
      chk("len edit frame_cnt", int'(frame_cnt), 3);

      // ---------------- randomized run against the timeline model
      resp_en = 1'b0; resp_cnt = 0; auto_en = 1'b1; wr_done = 1'b0;
      Rst = 1'b1; step(); Rst = 1'b0;
      m_idle = 0; m_valid = 1'b0; m_pend = 1'b0; m_bank = 1'b1;
      m_ovr = 1'b0; m_fcnt = 8'd0; m_len = 0; m_lat_s = 0;
      for (int c = 0; c < RND_CYC; c++) begin
         if ($urandom_range(0, 3) == 0) frame_len = AW'($urandom_range(0, 15));
         if (c == m_idle + 1) begin
            // START cycle: lay out the whole frame's timeline up front
            m_len = int'(frame_len);
            m_req[0] = c + 1;
            for (int k = 0; k <= m_len; k++) begin
               if (k > 0) m_req[k] = m_done[k-1] + 1;
               m_done[k] = m_req[k] + int'($urandom_range(1, 4));
            end
            m_lat_s = m_done[m_len] + 1;
            m_idle  = m_lat_s + L;
            m_valid = 1'b1;
         end
         wd_real = 1'b0; in_wait = 1'b0; e_req = 1'b0; e_addr = 0;
         if (m_valid) begin
            for (int k = 0; k <= m_len; k++) begin
               if (m_done[k] == c) wd_real = 1'b1;
               if (m_req[k] < c && c <= m_done[k]) in_wait = 1'b1;
               if (m_req[k] == c) begin e_req = 1'b1; e_addr = k; end
            end
         end
         word_done = wd_real | (!in_wait && $urandom_range(0, 5) == 0);
         wr_done   = ($urandom_range(0, 15) == 0);
         e_low  = m_valid && c >= m_lat_s && c < m_lat_s + L;
         e_busy = (c != m_idle);

         @(negedge clk);
         ok = (word_req == e_req) && (!e_req || int'(rd_addr) == e_addr) &&
              (rd_bank == m_bank) && (wr_bank == !m_bank) && (line_low == e_low) &&
              (busy == e_busy) && (frame_cnt == m_fcnt) && (err_ovr == m_ovr) && !err_tmo;
         checks++;
         if (!ok) begin
            errors++;
            $display("FAIL rnd cyc %0d: got req=%b addr=%0d bank=%b/%b low=%b busy=%b fcnt=%0d ovr=%b tmo=%b, want req=%b addr=%0d bank=%b low=%b busy=%b fcnt=%0d ovr=%b tmo=0",
                     c, word_req, rd_addr, rd_bank, wr_bank, line_low, busy, frame_cnt, err_ovr, err_tmo,
                     e_req, e_addr, m_bank, e_low, e_busy, m_fcnt, m_ovr);
         end

         consume = (c == m_idle) && m_pend;
         if (wr_done) begin
            if (!m_pend || consume) m_pend = 1'b1;
            else m_ovr = 1'b1;
         end else if (consume) begin
            m_pend = 1'b0;
         end
         if (consume) m_bank = !m_bank;
         if (m_valid && c == m_lat_s + L - 1) m_fcnt = m_fcnt + 8'd1;

         @(posedge clk);
         #1;
      end
      wr_done = 1'b0; word_done = 1'b0; auto_en = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL global timeout: got no finish, want finish");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
